// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - column-serial (Inv)MixColumns engine with valid/ready handshake
module inv_mix_columns_seq #(
  parameter bit enc_dec = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   col;
  logic [0:127] st;
  logic [0:31]  cur_col;
  logic [0:31]  mixed_col;

  // Multiply by x in GF(2^8) mod 0x11B; bit 0 is the byte MSB.
  function automatic logic [0:7] xtime(input logic [0:7] b);
    return {b[1:7], 1'b0} ^ (b[0] ? 8'h1b : 8'h00);
  endfunction

  // Product of a byte with entry j of the first matrix row, built from xtime chains.
  function automatic logic [0:7] coef_mul(input logic [0:7] b, input logic [1:0] j);
    logic [0:7] x2;
    logic [0:7] x4;
    logic [0:7] x8;
    logic [0:7] p;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    p  = 8'h00;
    if (enc_dec) begin
      case (j)
        2'd0:    p = x8 ^ x4 ^ x2;   // 0e
        2'd1:    p = x8 ^ x2 ^ b;    // 0b
        2'd2:    p = x8 ^ x4 ^ b;    // 0d
        default: p = x8 ^ b;         // 09
      endcase
    end else begin
      case (j)
        2'd0:    p = x2;             // 02
        2'd1:    p = x2 ^ b;         // 03
        default: p = b;              // 01
      endcase
    end
    return p;
  endfunction

  // Row r of the matrix is the first row rotated right by r, so the
  // coefficient applied to byte k in row r is first-row entry (k - r) mod 4.
  function automatic logic [0:31] mix_col(input logic [0:31] c);
    logic [0:31] res;
    logic [0:7]  acc;
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) begin
        acc = acc ^ coef_mul(c[8*k +: 8], 2'(k - r));
      end
      res[8*r +: 8] = acc;
    end
    return res;
  endfunction

  // Single shared column datapath, selected by the column counter.
  always_comb begin
    cur_col   = st[{col, 5'b0} +: 32];
    mixed_col = mix_col(cur_col);
  end

  // Handshake FSM, column sequencing and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= 2'd0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data;
            col      <= 2'd0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          st[{col, 5'b0} +: 32] <= mixed_col;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          col       <= 2'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = st;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - randomized self-checking bench for inv_mix_columns_seq
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;

  logic         dec_in_valid, dec_in_ready, dec_out_valid, dec_out_ready, dec_busy;
  logic [127:0] dec_in_data, dec_out_data;
  logic         enc_in_valid, enc_in_ready, enc_out_valid, enc_out_ready, enc_busy;
  logic [127:0] enc_in_data, enc_out_data;

  int checks = 0;
  int errors = 0;

  inv_mix_columns_seq #(.enc_dec(1'b1)) dut_dec (
    .clk(clk), .rst_n(rst_n),
    .in_valid(dec_in_valid), .in_ready(dec_in_ready), .in_data(dec_in_data),
    .out_valid(dec_out_valid), .out_ready(dec_out_ready), .out_data(dec_out_data),
    .busy(dec_busy)
  );

  inv_mix_columns_seq #(.enc_dec(1'b0)) dut_enc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(enc_in_valid), .in_ready(enc_in_ready), .in_data(enc_in_data),
    .out_valid(enc_out_valid), .out_ready(enc_out_ready), .out_data(enc_out_data),
    .busy(enc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Matrix-times-column for every column; byte i = 4*col + row, leftmost byte first.
  function automatic logic [127:0] ref_mix(input logic [127:0] v, input bit dec);
    logic [7:0]   row0 [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (dec) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = v[127 - 8*(4*c + k) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(row0[(k - rr + 4) % 4], a[k]);
        r[127 - 8*(4*c + rr) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one state into the selected instance with out_ready high; report result and latency.
  task automatic transact(input bit dec, input logic [127:0] din,
                          output logic [127:0] dout, output int lat);
    int w;
    w = 0;
    while (((dec ? dec_in_ready : enc_in_ready) !== 1'b1) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (dec) begin dec_in_valid = 1'b1; dec_in_data = din; dec_out_ready = 1'b1; end
    else     begin enc_in_valid = 1'b1; enc_in_data = din; enc_out_ready = 1'b1; end
    @(posedge clk); #1;
    dec_in_valid = 1'b0;
    enc_in_valid = 1'b0;
    lat = 0;
    while (((dec ? dec_out_valid : enc_out_valid) !== 1'b1) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    dout = dec ? dec_out_data : enc_out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [127:0] d;
    rst_n = 1'b0;
    dec_in_valid = 0; dec_out_ready = 0; dec_in_data = '0;
    enc_in_valid = 0; enc_out_ready = 0; enc_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dec_out_valid !== 1'b0 || dec_busy !== 1'b0 || dec_out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: ov=%b busy=%b data=%h required ov=0 busy=0 data=0",
               dec_out_valid, dec_busy, dec_out_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (dec_in_ready !== 1'b1 || enc_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: dec=%b enc=%b required 1", dec_in_ready, enc_in_ready);
    end
    // Abort mid-BUSY.
    @(posedge clk); #1;
    d = rand128() | 128'h1;
    dec_in_valid = 1'b1; dec_in_data = d;
    @(posedge clk); #1;
    dec_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dec_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_flag: got %b required 1", dec_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dec_out_valid !== 1'b0 || dec_busy !== 1'b0 || dec_out_data !== 128'h0) begin
      errors++;
      $display("FAIL async_reset_midbusy: ov=%b busy=%b data=%h required 0/0/0",
               dec_out_valid, dec_busy, dec_out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (dec_in_ready !== 1'b1 || dec_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: in_ready=%b busy=%b required 1/0", dec_in_ready, dec_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [127:0] o;
    int lat;
    transact(1'b1, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, o, lat);
    checks++;
    if (o !== 128'hdb135345_f20a225c_01010101_d4d4d4d5) begin
      errors++;
      $display("FAIL dec_vector: got %h required db135345f20a225c01010101d4d4d4d5", o);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL dec_latency: got %0d required 4", lat);
    end
    transact(1'b0, 128'hdb135345_f20a225c_01010101_d4d4d4d5, o, lat);
    checks++;
    if (o !== 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6) begin
      errors++;
      $display("FAIL enc_vector: got %h required 8e4da1bc9fdc589d01010101d5d5d7d6", o);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL enc_latency: got %0d required 4", lat);
    end
  endtask

  task automatic test_identity();
    logic [127:0] o;
    logic [127:0] pats [2];
    int lat;
    pats[0] = {4{32'hc6c6c6c6}};
    pats[1] = 128'h0;
    for (int p = 0; p < 2; p++) begin
      for (int m = 0; m < 2; m++) begin
        transact(m[0], pats[p], o, lat);
        checks++;
        if (o !== pats[p] || lat !== 4) begin
          errors++;
          $display("FAIL identity mode=%0d: got %h lat=%0d required %h lat=4", m, o, lat, pats[p]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] x, o, o2;
    int lat;
    for (int i = 0; i < 12; i++) begin
      x = rand128();
      transact(1'b1, x, o, lat);
      checks++;
      if (o !== ref_mix(x, 1'b1) || lat !== 4) begin
        errors++;
        $display("FAIL random_dec in=%h: got %h lat=%0d required %h", x, o, lat, ref_mix(x, 1'b1));
      end
      transact(1'b0, x, o, lat);
      checks++;
      if (o !== ref_mix(x, 1'b0) || lat !== 4) begin
        errors++;
        $display("FAIL random_enc in=%h: got %h lat=%0d required %h", x, o, lat, ref_mix(x, 1'b0));
      end
      transact(1'b1, o, o2, lat);
      checks++;
      if (o2 !== x) begin
        errors++;
        $display("FAIL round_trip: got %h required %h", o2, x);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, exp;
    int w;
    a = rand128();
    exp = ref_mix(a, 1'b1);
    dec_out_ready = 1'b0;
    dec_in_valid = 1'b1; dec_in_data = a;
    @(posedge clk); #1;
    dec_in_valid = 1'b0;
    w = 0;
    while (dec_out_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (w !== 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d required 4", w);
    end
    for (int i = 0; i < 10; i++) begin
      dec_in_valid = i[0];
      dec_in_data = rand128();
      @(posedge clk); #1;
      checks++;
      if (dec_out_valid !== 1'b1 || dec_out_data !== exp || dec_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: ov=%b data=%h in_ready=%b required 1 %h 0",
                 i, dec_out_valid, dec_out_data, dec_in_ready, exp);
      end
    end
    dec_in_valid = 1'b0;
    dec_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dec_out_valid !== 1'b0 || dec_in_ready !== 1'b1 || dec_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ov=%b in_ready=%b busy=%b required 0/1/0",
               dec_out_valid, dec_in_ready, dec_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q [9];
    logic [127:0] exp [9];
    int out_cyc [9];
    int acc_cyc [9];
    int sent, got, cyc;
    logic rdy, ov;
    logic [127:0] od;
    q[0] = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    for (int i = 1; i < 9; i++) q[i] = rand128();
    for (int i = 0; i < 9; i++) exp[i] = ref_mix(q[i], 1'b1);
    sent = 0; got = 0; cyc = 0;
    dec_out_ready = 1'b1;
    dec_in_valid = 1'b1;
    dec_in_data = q[0];
    while (got < 9 && cyc < 200) begin
      rdy = dec_in_ready; ov = dec_out_valid; od = dec_out_data;
      if (ov === 1'b1) begin
        checks++;
        if (od !== exp[got]) begin
          errors++;
          $display("FAIL stream_data idx=%0d: got %h required %h", got, od, exp[got]);
        end
        out_cyc[got] = cyc;
        got++;
      end
      if (rdy === 1'b1 && dec_in_valid === 1'b1) begin
        acc_cyc[sent] = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (sent < 9) dec_in_data = q[sent];
      else          dec_in_valid = 1'b0;
    end
    dec_in_valid = 1'b0;
    checks++;
    if (got !== 9) begin
      errors++;
      $display("FAIL stream_count: got %0d required 9", got);
    end
    for (int i = 1; i < got; i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] !== 6 || acc_cyc[i] - acc_cyc[i-1] !== 6) begin
        errors++;
        $display("FAIL stream_spacing idx=%0d: out=%0d acc=%0d required 6",
                 i, out_cyc[i] - out_cyc[i-1], acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    if (got > 0) begin
      checks++;
      if (out_cyc[0] - acc_cyc[0] !== 5) begin
        errors++;
        $display("FAIL stream_first_latency: got %0d required 5 samples", out_cyc[0] - acc_cyc[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_identity();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
